// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time, presents {pc, inst} to execute.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module ifu_fetch #(
  parameter int unsigned          XLEN     = 64,
  parameter logic [XLEN-1:0]      RESET_PC = 64'h0000000080000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]     perf_fetched,
  output logic [63:0]     perf_stall,
  output logic [31:0]     perf_flush
`endif
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            drop, drop_n;
  logic            capture;
  logic            flush;

  assign imem_req_valid = (state == REQ) && !rst;
  assign imem_req_addr  = pc;
  assign out_valid      = (state == HOLD);

  // Redirect always wins the pc update; drop marks an in-flight response as stale.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    drop_n  = drop;
    capture = 1'b0;
    flush   = 1'b0;
    unique case (state)
      REQ: begin
        if (imem_req_ready) begin
          state_n = WAIT;
          if (redirect_valid) begin
            drop_n = 1'b1;
            flush  = 1'b1;
          end
        end
        if (redirect_valid) pc_n = redirect_pc;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (redirect_valid) begin
            pc_n    = redirect_pc;
            drop_n  = 1'b0;
            state_n = REQ;
          end else if (drop) begin
            drop_n  = 1'b0;
            state_n = REQ;
          end else begin
            capture = 1'b1;
            state_n = HOLD;
          end
        end else if (redirect_valid) begin
          pc_n   = redirect_pc;
          drop_n = 1'b1;
          flush  = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_n    = redirect_pc;
          state_n = REQ;
          flush   = 1'b1;
        end else if (out_ready) begin
          pc_n    = pc + XLEN'(4);
          state_n = REQ;
        end
      end
      default: state_n = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= REQ;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      out_pc   <= '0;
      out_inst <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      drop  <= drop_n;
      if (capture) begin
        out_pc   <= pc;
        out_inst <= imem_rsp_data;
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flush   <= '0;
    end else begin
      if (out_valid && out_ready)
        perf_fetched <= perf_fetched + 64'd1;
      if ((state == WAIT) || ((state == REQ) && !imem_req_ready))
        perf_stall <= perf_stall + 64'd1;
      if (flush)
        perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed table-driven bench for ifu_fetch plus hand sequences for redirect/drop and pc wrap.
module tb_ifu_fetch;

  localparam logic [63:0] A = 64'h0000000080000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetched;
  logic [63:0] perf_stall;
  logic [31:0] perf_flush;
  logic [63:0] stall_snap;
`endif

  int errors = 0;
  int checks = 0;

  ifu_fetch #(.XLEN(64), .RESET_PC(A)) dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_inst(out_inst)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall(perf_stall),
    .perf_flush(perf_flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdv;
    logic [63:0] rdpc;
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        ordy;
    logic        erv;
    logic [63:0] eaddr;
    logic        eov;
    logic [63:0] eopc;
    logic [31:0] eoi;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];

  function automatic vec_t mk(logic r, logic rdv, logic [63:0] rdpc, logic rdy,
                              logic rspv, logic [31:0] rspd, logic ordy,
                              logic erv, logic [63:0] eaddr, logic eov,
                              logic [63:0] eopc, logic [31:0] eoi);
    vec_t v;
    v.rst = r; v.rdv = rdv; v.rdpc = rdpc; v.rdy = rdy; v.rspv = rspv;
    v.rspd = rspd; v.ordy = ordy; v.erv = erv; v.eaddr = eaddr;
    v.eov = eov; v.eopc = eopc; v.eoi = eoi;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdv, input logic [63:0] rdpc,
                       input logic rdy, input logic rspv, input logic [31:0] rspd,
                       input logic ordy);
    rst = r; redirect_valid = rdv; redirect_pc = rdpc; imem_req_ready = rdy;
    imem_rsp_valid = rspv; imem_rsp_data = rspd; out_ready = ordy;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    // 0-1: reset state, then first fetch of 0x413
    tbl[0]  = mk(1, 0, 64'h0,     0, 0, 32'h0,        0, 0, A,        0, 64'h0,    32'h0);
    tbl[1]  = mk(0, 0, 64'h0,     1, 0, 32'h0,        1, 1, A,        0, 64'h0,    32'h0);
    tbl[2]  = mk(0, 0, 64'h0,     1, 1, 32'h00000413, 1, 0, A,        0, 64'h0,    32'h0);
    tbl[3]  = mk(0, 0, 64'h0,     1, 0, 32'h0,        1, 0, A,        1, A,        32'h00000413);
    tbl[4]  = mk(0, 0, 64'h0,     1, 0, 32'h0,        0, 1, A+4,      0, A,        32'h00000413);
    tbl[5]  = mk(0, 0, 64'h0,     1, 1, 32'h00100093, 0, 0, A+4,      0, A,        32'h00000413);
    // HOLD backpressure for 5 cycles with a stray response and ready high
    for (int i = 6; i <= 10; i++)
      tbl[i] = mk(0, 0, 64'h0,    1, 1, 32'hdeadbeef, 0, 0, A+4,      1, A+4,      32'h00100093);
    tbl[11] = mk(0, 0, 64'h0,     1, 0, 32'h0,        1, 0, A+4,      1, A+4,      32'h00100093);
    tbl[12] = mk(0, 0, 64'h0,     1, 0, 32'h0,        0, 1, A+8,      0, A+4,      32'h00100093);
    tbl[13] = mk(0, 0, 64'h0,     1, 1, 32'h00208113, 0, 0, A+8,      0, A+4,      32'h00100093);
    // redirect coincident with handshake in HOLD
    tbl[14] = mk(0, 1, A+'h200,   1, 0, 32'h0,        1, 0, A+8,      1, A+8,      32'h00208113);
    for (int i = 15; i <= 18; i++)
      tbl[i] = mk(0, 0, 64'h0,    0, 0, 32'h0,        0, 1, A+'h200,  0, A+8,      32'h00208113);
    tbl[19] = mk(0, 0, 64'h0,     1, 0, 32'h0,        0, 1, A+'h200,  0, A+8,      32'h00208113);
    // redirect in WAIT, response two cycles later must be dropped
    tbl[20] = mk(0, 1, A+'h100,   0, 0, 32'h0,        0, 0, A+'h200,  0, A+8,      32'h00208113);
    tbl[21] = mk(0, 0, 64'h0,     0, 0, 32'h0,        0, 0, A+'h100,  0, A+8,      32'h00208113);
    tbl[22] = mk(0, 0, 64'h0,     0, 1, 32'h00000bad, 0, 0, A+'h100,  0, A+8,      32'h00208113);
    tbl[23] = mk(0, 0, 64'h0,     1, 0, 32'h0,        0, 1, A+'h100,  0, A+8,      32'h00208113);
    tbl[24] = mk(0, 0, 64'h0,     0, 1, 32'h00000513, 0, 0, A+'h100,  0, A+8,      32'h00208113);
    tbl[25] = mk(0, 0, 64'h0,     0, 0, 32'h0,        1, 0, A+'h100,  1, A+'h100,  32'h00000513);
    tbl[26] = mk(0, 0, 64'h0,     1, 0, 32'h0,        0, 1, A+'h104,  0, A+'h100,  32'h00000513);
    // reset while in WAIT, stale response right after
    tbl[27] = mk(1, 0, 64'h0,     0, 0, 32'h0,        0, 0, A+'h104,  0, A+'h100,  32'h00000513);
    tbl[28] = mk(0, 0, 64'h0,     0, 1, 32'h00000bad, 0, 1, A,        0, 64'h0,    32'h0);
    tbl[29] = mk(0, 0, 64'h0,     0, 0, 32'h0,        0, 1, A,        0, 64'h0,    32'h0);

    repeat (2) cyc();

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].rdv, tbl[i].rdpc, tbl[i].rdy, tbl[i].rspv, tbl[i].rspd, tbl[i].ordy);
      #1;
      chk($sformatf("v%0d.req_valid", i), 64'(imem_req_valid), 64'(tbl[i].erv));
      chk($sformatf("v%0d.req_addr", i),  imem_req_addr,         tbl[i].eaddr);
      chk($sformatf("v%0d.out_valid", i), 64'(out_valid),        64'(tbl[i].eov));
      chk($sformatf("v%0d.out_pc", i),    out_pc,                tbl[i].eopc);
      chk($sformatf("v%0d.out_inst", i),  64'(out_inst),         64'(tbl[i].eoi));
      cyc();
    end

    // request stall: valid and address stable for 4 cycles
`ifdef IFU_PERF_CNT_EN
    stall_snap = perf_stall;
`endif
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      chk($sformatf("stall%0d.req_valid", i), 64'(imem_req_valid), 64'd1);
      chk($sformatf("stall%0d.req_addr", i),  imem_req_addr, A);
      cyc();
    end
`ifdef IFU_PERF_CNT_EN
    chk("perf_stall_delta", perf_stall - stall_snap, 64'd4);
`endif

    // redirect while the request is accepted: old pc issued, response dropped
    drive(1'b0, 1'b1, A+'h300, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    chk("rq_rd.req_valid", 64'(imem_req_valid), 64'd1);
    chk("rq_rd.req_addr", imem_req_addr, A);
    cyc();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 32'h00000bad, 1'b0);
    #1;
    chk("rq_rd.wait_addr", imem_req_addr, A+'h300);
    cyc();
    drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    chk("rq_rd.dropped_ov", 64'(out_valid), 64'd0);
    chk("rq_rd.req_valid2", 64'(imem_req_valid), 64'd1);
    chk("rq_rd.req_addr2", imem_req_addr, A+'h300);
    cyc();

    // redirect coincident with a response, target near the top for wrap
    drive(1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b1, 32'h00000111, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    chk("wr.ov_after_rsp_rd", 64'(out_valid), 64'd0);
    chk("wr.req_valid", 64'(imem_req_valid), 64'd1);
    chk("wr.req_addr", imem_req_addr, 64'hFFFFFFFFFFFFFFFC);
    cyc();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 32'h00000222, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("wr.out_valid", 64'(out_valid), 64'd1);
    chk("wr.out_pc", out_pc, 64'hFFFFFFFFFFFFFFFC);
    chk("wr.out_inst", 64'(out_inst), 64'h222);
    cyc();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("wr.next_addr", imem_req_addr, 64'h0);
    chk("wr.next_ov", 64'(out_valid), 64'd0);
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 64'd1);
    chk("perf_flush", 64'(perf_flush), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage directly upstream of the single-cycle execute core.
- Owns the architectural PC and issues 32-bit instruction reads to instruction memory over a valid/ready request plus a valid-only response.
- Presents each fetched {pc, inst} to the execute core through a valid/ready handshake.
- Accepts control-flow redirects from execute, e.g. jumps, branches and ebreak halt-to-vector.

Parameters:
- RESET_PC, 64'h0000000080000000, PC loaded on reset.
- XLEN, 64, width of PC and memory address.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- redirect_valid  input  1  redirect request from execute.
- redirect_pc  input  XLEN  redirect target.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  XLEN  fetch address (= pc register).
- imem_rsp_valid  input  1  response data valid; arrives at earliest 1 cycle after request acceptance.
- imem_rsp_data  input  32  fetched instruction.
- out_valid  output  1  {out_pc, out_inst} valid to execute.
- out_ready  input  1  execute consumes instruction.
- out_pc  output  XLEN  PC of presented instruction.
- out_inst  output  32  presented instruction.

Behaviour:
- Reset
  - rst is sampled on clk; reset is synchronous, active-high.
  - Reset loads pc=RESET_PC, state=REQ, drop=0, out_valid=0, out_pc=0, out_inst=0.
  - imem_req_valid is forced 0 while rst=1.
  - Reset mid-operation abandons any outstanding request. A stale imem_rsp_valid arriving in REQ is ignored.
- States: REQ, WAIT, HOLD.
  - imem_req_valid = (state==REQ) && !rst.
  - imem_req_addr = pc.
  - out_valid = (state==HOLD).
- REQ
  - On imem_req_ready -> WAIT.
  - Otherwise stay in REQ; addr must remain stable while valid && !ready.
- WAIT
  - On imem_rsp_valid with drop=0: out_inst<=rsp_data, out_pc<=pc -> HOLD.
  - On imem_rsp_valid with drop=1: discard data, drop<=0 -> REQ.
  - imem_rsp_valid in REQ or HOLD is ignored.
- HOLD
  - out_pc and out_inst are held stable until out_valid && out_ready.
  - On handshake: pc<=pc+4 (mod 2^XLEN, wraps silently) -> REQ.
- Redirect priority: redirect_valid beats all other pc updates.
  - REQ, no ready: pc<=redirect_pc, stay REQ.
  - REQ with ready: the request is issued with the old pc; pc<=redirect_pc, drop<=1 -> WAIT.
  - WAIT, no rsp: pc<=redirect_pc, drop<=1.
  - WAIT with rsp: discard rsp, pc<=redirect_pc, drop<=0 -> REQ.
  - HOLD, with or without out_ready: pc<=redirect_pc -> REQ. If out_ready was also high, the instruction counts as consumed. out_valid drops next cycle.
- redirect_pc bits[1:0] are used unmodified; alignment is the execute core's responsibility.
- At most one request outstanding.
- Minimum throughput: 3 cycles per instruction (REQ, WAIT, HOLD) with zero-wait memory and out_ready=1.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- When defined, adds outputs:
  - perf_fetched (64): increments on each out handshake.
  - perf_stall (64): increments each cycle state==WAIT, or state==REQ && !imem_req_ready.
  - perf_flush (32): increments on each redirect_valid that sets drop or leaves HOLD.
- All counters reset to 0 on rst and wrap at their maximum.
- When undefined, these ports and registers do not exist; remaining behaviour is identical.

Test Plan:
- Reset then out_ready=1, zero-wait memory returning 32'h00000413 -> first req addr 0x80000000 on the cycle after rst deasserts. out_pc=0x80000000, inst=0x00000413. Next req addr 0x80000004; handshakes every 3 cycles.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid, out_pc and out_inst stable all 5 cycles; no new request issued.
- Redirect in WAIT to 0x80000100, rsp arrives 2 cycles later -> response discarded, out_valid stays 0. Next req addr 0x80000100.
- Redirect coincident with out handshake in HOLD at pc 0x80000008 to 0x80000200 -> instruction consumed once. Next req addr 0x80000200, not 0x8000000C.
- Stall imem_req_ready=0 for 4 cycles -> imem_req_valid high and addr unchanged throughout; with IFU_PERF_CNT_EN, perf_stall increases by 4.
- rst asserted while in WAIT, stale rsp arrives the cycle after rst drops -> ignored. Req addr = 0x80000000, out_valid=0.
